main_fsm: RTL and testbench

Main control state machine of the multi-cycle RV32I controller. Sequences each instruction through fetch, decode, execute, memory and writeback steps based on the 7-bit opcode. Drives the datapath multiplexer selects and write strobes, and produces the 2-bit `ALUOp` consumed directly by the ALU decoder. It waits on a single memory-ready handshake for instruction fetch, load and store.

---
 rtl/main_fsm.sv | 169 ++++++++++++++++
 tb/tb_main_fsm.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// main_fsm: multi-cycle RV32I control sequencer.
// Steps fetch/decode/execute/mem/writeback from the opcode.
module main_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       illegal_instr
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  state_t state;
  state_t state_nx;

  logic is_lw;
  logic is_sw;
  logic is_r;
  logic is_i;
  logic is_beq;
  logic is_jal;

  logic irw;
  logic pcu;
  logic br;
  logic rw;
  logic mw;
  logic ill;

  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_r   = (op == OP_R);
  assign is_i   = (op == OP_I);
  assign is_beq = (op == OP_BEQ);
  assign is_jal = (op == OP_JAL);

  // state register; reset drops straight back to FETCH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= state_nx;
  end

  // next state and Moore outputs
  always_comb begin
    state_nx  = state;
    AdrSrc    = 1'b0;
    irw       = 1'b0;
    pcu       = 1'b0;
    br        = 1'b0;
    rw        = 1'b0;
    mw        = 1'b0;
    ill       = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    unique case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = mem_ready;
        pcu       = mem_ready;
        if (mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (1'b1)
          is_lw, is_sw: state_nx = S_MEMADR;
          is_r:         state_nx = S_EXECR;
          is_i:         state_nx = S_EXECI;
          is_beq:       state_nx = S_BEQ;
          is_jal:       state_nx = S_JAL;
          default: begin
            ill      = 1'b1;
            state_nx = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        if (is_lw)      state_nx = S_MEMREAD;
        else if (is_sw) state_nx = S_MEMWRITE;
        else            state_nx = S_FETCH;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = 1'b1;
        state_nx  = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = 1'b1;
        if (mem_ready) state_nx = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b10;
        state_nx = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        ALUOp    = 2'b10;
        state_nx = S_ALUWB;
      end
      S_ALUWB: begin
        rw       = 1'b1;
        state_nx = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        ALUOp    = 2'b01;
        br       = 1'b1;
        state_nx = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcu      = 1'b1;
        state_nx = S_ALUWB;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // strobes are held off for as long as reset is asserted
  assign IRWrite       = irw & reset_n;
  assign PCUpdate      = pcu & reset_n;
  assign Branch        = br  & reset_n;
  assign RegWrite      = rw  & reset_n;
  assign MemWrite      = mw  & reset_n;
  assign illegal_instr = ill & reset_n;

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: randomized scoreboard bench for main_fsm.
// Per-cycle control words come from an instruction-level model.
module tb_main_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct {
    logic        rst;
    logic        mr;
    logic [6:0]  op;
    logic [14:0] exp;
  } step_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mem_ready = 1'b0;
  logic [6:0] op = 7'd0;

  logic       AdrSrc;
  logic       IRWrite;
  logic       PCUpdate;
  logic       Branch;
  logic       RegWrite;
  logic       MemWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUOp;
  logic       illegal_instr;

  step_t       plan[$];
  logic [14:0] exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  main_fsm dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .op            (op),
    .mem_ready     (mem_ready),
    .AdrSrc        (AdrSrc),
    .IRWrite       (IRWrite),
    .PCUpdate      (PCUpdate),
    .Branch        (Branch),
    .RegWrite      (RegWrite),
    .MemWrite      (MemWrite),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ResultSrc     (ResultSrc),
    .ALUOp         (ALUOp),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  wire [14:0] got = {AdrSrc, IRWrite, PCUpdate, Branch,
                     RegWrite, MemWrite, ALUSrcA, ALUSrcB,
                     ResultSrc, ALUOp, illegal_instr};

  function automatic logic [14:0] w(
    input logic adr, input logic irw, input logic pcu,
    input logic br, input logic rw, input logic mw,
    input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] res, input logic [1:0] alu,
    input logic ill);
    return {adr, irw, pcu, br, rw, mw, a, b, res, alu, ill};
  endfunction

  function automatic logic supported(input logic [6:0] o);
    return o == OP_LW || o == OP_SW || o == OP_R ||
           o == OP_I || o == OP_BEQ || o == OP_JAL;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(1, 0));
  endfunction

  task automatic push(input logic rst, input logic mr,
                      input logic [6:0] o, input logic [14:0] e);
    step_t s;
    s.rst = rst;
    s.mr  = mr;
    s.op  = o;
    s.exp = e;
    plan.push_back(s);
  endtask

  task automatic add_reset(input int n);
    logic [14:0] idle;
    idle = w(0,0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,0);
    for (int i = 0; i < n; i++)
      push(1'b0, rbit(), 7'($urandom), idle);
  endtask

  // expected trace of one instruction, fetch stalls fs, mem stalls ms
  task automatic add_instr(input logic [6:0] o, input int fs,
                           input int ms);
    logic [14:0] fidle, fgo, dec, madr, mrd, mwb, mwr;
    logic [14:0] exr, exi, awb, beq, jal;
    fidle = w(0,0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,0);
    fgo   = w(0,1,1,0,0,0,2'b00,2'b10,2'b10,2'b00,0);
    dec   = w(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,
              !supported(o));
    madr  = w(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0);
    mrd   = w(1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0);
    mwb   = w(0,0,0,0,1,0,2'b00,2'b00,2'b01,2'b00,0);
    mwr   = w(1,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0);
    exr   = w(0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b10,0);
    exi   = w(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b10,0);
    awb   = w(0,0,0,0,1,0,2'b00,2'b00,2'b00,2'b00,0);
    beq   = w(0,0,0,1,0,0,2'b10,2'b00,2'b00,2'b01,0);
    jal   = w(0,0,1,0,0,0,2'b01,2'b10,2'b00,2'b00,0);
    for (int i = 0; i < fs; i++)
      push(1'b1, 1'b0, 7'($urandom), fidle);
    push(1'b1, 1'b1, 7'($urandom), fgo);
    push(1'b1, rbit(), o, dec);
    if (o == OP_LW) begin
      push(1'b1, rbit(), o, madr);
      for (int i = 0; i < ms; i++) push(1'b1, 1'b0, o, mrd);
      push(1'b1, 1'b1, o, mrd);
      push(1'b1, rbit(), o, mwb);
    end else if (o == OP_SW) begin
      push(1'b1, rbit(), o, madr);
      for (int i = 0; i < ms; i++) push(1'b1, 1'b0, o, mwr);
      push(1'b1, 1'b1, o, mwr);
    end else if (o == OP_R) begin
      push(1'b1, rbit(), o, exr);
      push(1'b1, rbit(), o, awb);
    end else if (o == OP_I) begin
      push(1'b1, rbit(), o, exi);
      push(1'b1, rbit(), o, awb);
    end else if (o == OP_BEQ) begin
      push(1'b1, rbit(), o, beq);
    end else if (o == OP_JAL) begin
      push(1'b1, rbit(), o, jal);
      push(1'b1, rbit(), o, awb);
    end
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] o;
    case ($urandom_range(6, 0))
      0: o = OP_LW;
      1: o = OP_SW;
      2: o = OP_R;
      3: o = OP_I;
      4: o = OP_BEQ;
      5: o = OP_JAL;
      default: begin
        o = 7'($urandom);
        while (supported(o)) o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  // monitor: one control word per cycle, mid-cycle
  always @(negedge clk) begin
    logic [14:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL ctrl cycle %0d: got %b expected %b",
                 cyc, got, e);
      end
    end
  end

  initial begin
    int sz;
    int k;
    add_reset(3);
    add_instr(OP_LW, 0, 2);
    add_instr(OP_R, 0, 0);
    add_instr(OP_BEQ, 0, 0);
    add_instr(OP_SW, 0, 3);
    add_instr(OP_JAL, 0, 0);
    add_instr(7'b1111111, 0, 0);
    add_instr(OP_I, 1, 0);
    add_instr(OP_LW, 0, 3);
    repeat (3) void'(plan.pop_back());
    add_reset(1);
    add_instr(OP_SW, 2, 1);
    for (int n = 0; n < 300; n++) begin
      sz = plan.size();
      add_instr(rand_op(), $urandom_range(2, 0),
                $urandom_range(3, 0));
      if ($urandom_range(19, 0) == 0) begin
        k = $urandom_range(plan.size() - sz - 1, 0);
        repeat (k) void'(plan.pop_back());
        add_reset($urandom_range(2, 1));
      end
    end

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      cyc       = i;
      reset_n   = plan[i].rst;
      mem_ready = plan[i].mr;
      op        = plan[i].op;
      exp_q.push_back(plan[i].exp);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d left, expected 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
